fp_mul_operand_queue: RTL and testbench

- Sits directly upstream of the combinational floating-point multiplier and buffers operand pairs in a DEPTH-entry FIFO.
- Presents the head entry on the multiplier's a / b / selector inputs, using a valid/ready handshake on both sides.
- At enqueue, classifies each operand for the selected precision (single or half) and precomputes an IEEE special-case result.
- The consumer uses that result in place of the multiplier product when out_special=1, because the multiplier handles normal operands only.

---
 rtl/fp_mul_operand_queue_if.sv | 30 +++
 rtl/fp_mul_operand_queue.sv | 132 +++++++++++++
 tb/tb_fp_mul_operand_queue.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_operand_queue_if.sv
// Operand-queue bus: upstream push side and multiplier-facing pop side.
interface fp_mul_operand_queue_if #(parameter int PTR_W = 2);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_half;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_a;
  logic [31:0]      out_b;
  logic             out_selector;
  logic             out_special;
  logic [31:0]      out_special_res;
  logic [PTR_W:0]   count;

  // Queue side
  modport slave (
    input  in_valid, in_a, in_b, in_half, out_ready,
    output in_ready, out_valid, out_a, out_b, out_selector,
           out_special, out_special_res, count
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_a, in_b, in_half, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_selector,
           out_special, out_special_res, count
  );
endinterface

// File: rtl/fp_mul_operand_queue.sv
// Operand FIFO in front of the FP multiplier. Classifies operands at enqueue
// and stores a precomputed IEEE special-case result alongside each pair.
module fp_mul_operand_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  fp_mul_operand_queue_if.slave q
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic        spec;
    logic [31:0] res;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  entry_t           in_ent, head;

  // Returns {special_flag, special_result}. Subnormals count as zero since
  // the multiplier downstream only handles normal operands.
  function automatic logic [32:0] special_case(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic        h);
    logic za, zb, oa, ob, mza, mzb, s;
    logic nan_a, nan_b, inf_a, inf_b;
    logic [31:0] qnan, inf, zero;
    za  = h ? (a[14:10] == 5'h0)  : (a[30:23] == 8'h0);
    zb  = h ? (b[14:10] == 5'h0)  : (b[30:23] == 8'h0);
    oa  = h ? (&a[14:10])         : (&a[30:23]);
    ob  = h ? (&b[14:10])         : (&b[30:23]);
    mza = h ? (a[9:0] == 10'h0)   : (a[22:0] == 23'h0);
    mzb = h ? (b[9:0] == 10'h0)   : (b[22:0] == 23'h0);
    s   = h ? (a[15] ^ b[15])     : (a[31] ^ b[31]);
    nan_a = oa & ~mza;
    nan_b = ob & ~mzb;
    inf_a = oa & mza;
    inf_b = ob & mzb;
    qnan = h ? 32'h0000_7E00 : 32'h7FC0_0000;
    inf  = h ? {16'h0, s, 5'h1F, 10'h0} : {s, 8'hFF, 23'h0};
    zero = h ? {16'h0, s, 15'h0}        : {s, 31'h0};
    if (nan_a || nan_b || (inf_a && zb) || (inf_b && za)) return {1'b1, qnan};
    else if (inf_a || inf_b)                              return {1'b1, inf};
    else if (za || zb)                                    return {1'b1, zero};
    else                                                  return 33'h0;
  endfunction

  assign q.in_ready  = (count_q != FULL_CNT);
  assign q.out_valid = (count_q != '0);
  assign push        = q.in_valid && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;
  assign head        = mem_q[rptr_q];

  // Format operands and precompute the special-case result for the new entry
  always_comb begin
    logic [32:0] sp;
    in_ent     = '0;
    in_ent.a   = q.in_half ? {16'h0, q.in_a[15:0]} : q.in_a;
    in_ent.b   = q.in_half ? {16'h0, q.in_b[15:0]} : q.in_b;
    in_ent.sel = q.in_half;
    sp         = special_case(q.in_a, q.in_b, q.in_half);
    in_ent.spec = sp[32];
    in_ent.res  = sp[31:0];
  end

  // Pointer/occupancy next state; flush clears like reset and beats push/pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem_q[wptr_q] <= in_ent;
  end

  // Drive head entry to the multiplier, forced to zero when the queue is empty
  always_comb begin
    q.out_a           = '0;
    q.out_b           = '0;
    q.out_selector    = 1'b0;
    q.out_special     = 1'b0;
    q.out_special_res = '0;
    if (q.out_valid) begin
      q.out_a           = head.a;
      q.out_b           = head.b;
      q.out_selector    = head.sel;
      q.out_special     = head.spec;
      q.out_special_res = head.res;
    end
  end

  assign q.count = count_q;

endmodule

// File: tb/tb_fp_mul_operand_queue.sv
// Randomized and directed bench for fp_mul_operand_queue with a queue-based model.
module tb_fp_mul_operand_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct {
    logic [31:0] a, b;
    logic        sel, spec;
    logic [31:0] res;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n, flush;
  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];

  fp_mul_operand_queue_if #(.PTR_W(PTR_W)) ifc ();
  fp_mul_operand_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .q(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // 0 zero, 1 inf, 2 nan, 3 normal
  function automatic int cls(input logic [31:0] x, input logic h);
    int e, emax, m;
    e    = h ? int'((x >> 10) & 32'h1F) : int'((x >> 23) & 32'hFF);
    emax = h ? 31 : 255;
    m    = h ? int'(x & 32'h3FF) : int'(x & 32'h7F_FFFF);
    if (e == 0)    return 0;
    if (e == emax) return (m == 0) ? 1 : 2;
    return 3;
  endfunction

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] b, input logic h);
    ent_t e;
    int ca, cb;
    logic s;
    e.a   = h ? (a & 32'hFFFF) : a;
    e.b   = h ? (b & 32'hFFFF) : b;
    e.sel = h;
    ca = cls(a, h);
    cb = cls(b, h);
    s  = h ? (a[15] ^ b[15]) : (a[31] ^ b[31]);
    e.spec = 1'b1;
    if (ca == 2 || cb == 2 || (ca == 1 && cb == 0) || (ca == 0 && cb == 1))
      e.res = h ? 32'h7E00 : 32'h7FC0_0000;
    else if (ca == 1 || cb == 1)
      e.res = h ? (32'h7C00 | (32'(s) << 15)) : (32'h7F80_0000 | (32'(s) << 31));
    else if (ca == 0 || cb == 0)
      e.res = h ? (32'(s) << 15) : (32'(s) << 31);
    else begin
      e.spec = 1'b0;
      e.res  = 32'h0;
    end
    return e;
  endfunction

  task automatic check_outputs();
    if (mq.size() == 0) begin
      chk("out_valid", 32'(ifc.out_valid), 32'd0);
      chk("out_a0", ifc.out_a, 32'h0);
      chk("out_b0", ifc.out_b, 32'h0);
      chk("sel0", 32'(ifc.out_selector), 32'd0);
      chk("spec0", 32'(ifc.out_special), 32'd0);
      chk("res0", ifc.out_special_res, 32'h0);
    end else begin
      chk("out_valid", 32'(ifc.out_valid), 32'd1);
      chk("out_a", ifc.out_a, mq[0].a);
      chk("out_b", ifc.out_b, mq[0].b);
      chk("sel", 32'(ifc.out_selector), 32'(mq[0].sel));
      chk("spec", 32'(ifc.out_special), 32'(mq[0].spec));
      chk("res", ifc.out_special_res, mq[0].res);
    end
    chk("count", 32'(ifc.count), 32'(mq.size()));
    chk("in_ready", 32'(ifc.in_ready), 32'(mq.size() != DEPTH));
  endtask

  // Called at negedge: check, drive one cycle of inputs, advance model, wait.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic h, input logic rdy, input logic fl, input logic rs);
    bit do_push, do_pop;
    check_outputs();
    ifc.in_valid  = v;
    ifc.in_a      = a;
    ifc.in_b      = b;
    ifc.in_half   = h;
    ifc.out_ready = rdy;
    flush         = fl;
    rst_n         = rs;
    if (!rs || fl) mq.delete();
    else begin
      do_push = v && (mq.size() < DEPTH);
      do_pop  = rdy && (mq.size() > 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(mk(a, b, h));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // Push one pair into an emptied queue and check the precomputed result directly
  task automatic spec1(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic h, input logic exp_sp, input logic [31:0] exp_res);
    clear();
    cyc(1'b1, a, b, h, 1'b0, 1'b0, 1'b1);
    chk({tag, "_sp"}, 32'(ifc.out_special), 32'(exp_sp));
    chk({tag, "_res"}, ifc.out_special_res, exp_res);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] pool [10];
    pool = '{32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000,
             32'h8000_0000, 32'h7FC0_0001, 32'h0000_3C00, 32'h0000_FC00,
             32'h0000_7C01, 32'h0000_8001};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 9)];
    return $urandom();
  endfunction

  initial begin
    ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_half = 1'b0;
    ifc.out_ready = 1'b0; flush = 1'b0; rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    mq.delete();
    idle();  // reset state checked here

    // Single normal operands, one-cycle latency
    cyc(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("norm_a", ifc.out_a, 32'h3F80_0000);
    chk("norm_b", ifc.out_b, 32'h4000_0000);
    chk("norm_cnt", 32'(ifc.count), 32'd1);
    chk("norm_sp", 32'(ifc.out_special), 32'd0);

    // Half formatting
    clear();
    cyc(1'b1, 32'hFFFF_3C00, 32'h1234_4000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("half_a", ifc.out_a, 32'h0000_3C00);
    chk("half_b", ifc.out_b, 32'h0000_4000);
    chk("half_sel", 32'(ifc.out_selector), 32'd1);
    chk("half_sp", 32'(ifc.out_special), 32'd0);

    // Full and ordering
    clear();
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 32'(i), 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 4) begin
        chk("full_rdy", 32'(ifc.in_ready), 32'd0);
        chk("full_cnt", 32'(ifc.count), 32'd4);
      end
    end
    chk("full_cnt5", 32'(ifc.count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("order", ifc.out_a, 32'(i));
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    chk("empty_vld", 32'(ifc.out_valid), 32'd0);
    cyc(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pushpop_cnt", 32'(ifc.count), 32'd2);
    chk("pushpop_head", ifc.out_a, 32'h4000_0000);

    // Special cases
    spec1("s_infzero", 32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h7FC0_0000);
    spec1("s_ninf",    32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b1, 32'hFF80_0000);
    spec1("s_nzero",   32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h8000_0000);
    spec1("h_ninf",    32'h0000_FC00, 32'h0000_4000, 1'b1, 1'b1, 32'h0000_FC00);
    spec1("h_nan",     32'h0000_7C01, 32'h0000_3C00, 1'b1, 1'b1, 32'h0000_7E00);
    spec1("h_sub",     32'h0000_0001, 32'h0000_3C00, 1'b1, 1'b1, 32'h0000_0000);

    // Flush with concurrent push
    clear();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fl_pre", 32'(ifc.count), 32'd3);
    cyc(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fl_cnt", 32'(ifc.count), 32'd0);
    chk("fl_vld", 32'(ifc.out_valid), 32'd0);
    chk("fl_a", ifc.out_a, 32'h0);

    // Reset mid-operation with pop requested
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_cnt", 32'(ifc.count), 32'd0);
    chk("rst_vld", 32'(ifc.out_valid), 32'd0);
    chk("rst_res", ifc.out_special_res, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 80) != 0);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
